// File: rtl/integration_signed_shift_multiplier_pkg.sv
// Purpose : shared types and constants for the signed shift-add multiplier.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package integration_signed_shift_multiplier_pkg;

  // Operand width used when the multiplier is instantiated without N.
  localparam int DEFAULT_N = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Iteration counter must hold 0..N.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/unsigned_shift_add_core.sv
// Purpose : unsigned right-shifting shift-add multiplier datapath (N x N -> 2N).
// Latency : N step cycles after load; step_acc shows the post-step accumulator.
// Backpressure: advances only on step; holds all state otherwise.
//
// Ports:
//   clock, reset  - rising-edge clock, async active-low reset
//   load          - capture magnitudes, clear accumulator
//   step          - perform one add-then-shift iteration
//   mcand_i       - multiplicand magnitude (unsigned N bits)
//   mplier_i      - multiplier magnitude (unsigned N bits)
//   step_acc      - accumulator value the current step would produce
module unsigned_shift_add_core #(
  parameter int N = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   mcand_i,
  input  logic [N-1:0]   mplier_i,
  output logic [2*N-1:0] step_acc
);

  logic [N-1:0]   mcand_q,  mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q,    acc_d;
  logic [N:0]     sum;

  // Add into the upper half with one extra carry bit, then shift right by
  // one; the carry becomes the new MSB so nothing is lost.
  always_comb begin
    sum      = {1'b0, acc_q[2*N-1:N]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    step_acc = {sum, acc_q[N-1:1]};
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
    end else if (step) begin
      mplier_d = mplier_q >> 1;
      acc_d    = step_acc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/integration_signed_shift_multiplier.sv
// Purpose : signed N x N multiplier built on an unsigned shift-add core.
// Latency : Z updates N edges after capture; <= N+2 edges after an operand change.
// Backpressure: en=0 freezes every register; an operand change in RUN aborts.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - async active-low reset
//   en     - advance enable
//   X, Y   - signed two's-complement operands
//   Z      - registered signed product, held between updates
module integration_signed_shift_multiplier
  import integration_signed_shift_multiplier_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           en,
  input  logic [N-1:0]   X,
  input  logic [N-1:0]   Y,
  output logic [2*N-1:0] Z
);

  localparam int CW = cnt_width(N);
  localparam int W2 = 2 * N;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [N-1:0]   x_cap_q, x_cap_d;
  logic [N-1:0]   y_cap_q, y_cap_d;
  logic           cap_done_q, cap_done_d;
  logic           sign_q,  sign_d;
  logic [W2-1:0]  z_q,     z_d;

  logic           load, step;
  logic           opnd_changed;
  logic [N-1:0]   x_mag, y_mag;
  logic [W2-1:0]  step_acc;

  // -2^(N-1) negates to itself, which read as unsigned is the correct
  // magnitude 2^(N-1).
  assign x_mag = X[N-1] ? (~X + N'(1)) : X;
  assign y_mag = Y[N-1] ? (~Y + N'(1)) : Y;

  assign opnd_changed = (X != x_cap_q) || (Y != y_cap_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_cap_d    = x_cap_q;
    y_cap_d    = y_cap_q;
    cap_done_d = cap_done_q;
    sign_d     = sign_q;
    z_d        = z_q;
    load       = 1'b0;
    step       = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (opnd_changed || !cap_done_q) begin
            x_cap_d    = X;
            y_cap_d    = Y;
            cap_done_d = 1'b1;
            sign_d     = X[N-1] ^ Y[N-1];
            load       = 1'b1;
            cnt_d      = '0;
            state_d    = RUN;
          end
        end
        RUN: begin
          if (opnd_changed) begin
            // Drop the partial result; IDLE recaptures on the next edge.
            state_d = IDLE;
          end else begin
            step  = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
              // A zero magnitude negates to zero, so no sign artefact.
              z_d     = sign_q ? (~step_acc + W2'(1)) : step_acc;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      x_cap_q    <= '0;
      y_cap_q    <= '0;
      cap_done_q <= 1'b0;
      sign_q     <= 1'b0;
      z_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_cap_q    <= x_cap_d;
      y_cap_q    <= y_cap_d;
      cap_done_q <= cap_done_d;
      sign_q     <= sign_d;
      z_q        <= z_d;
    end
  end

  unsigned_shift_add_core #(
    .N (N)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .mcand_i  (x_mag),
    .mplier_i (y_mag),
    .step_acc (step_acc)
  );

  assign Z = z_q;

endmodule

// File: tb/tb_integration_signed_shift_multiplier.sv
// Purpose : directed self-checking bench for integration_signed_shift_multiplier.
// Latency : checks exact update edges for idle, stalled and aborted runs.
// Backpressure: exercises en stalls and operand changes mid-run.
module tb_integration_signed_shift_multiplier;

  localparam int N = 32;

  logic           clock;
  logic           reset;
  logic           en;
  logic [N-1:0]   X;
  logic [N-1:0]   Y;
  logic [2*N-1:0] Z;

  int checks = 0;
  int errors = 0;

  integration_signed_shift_multiplier #(
    .N (N)
  ) dut (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .X     (X),
    .Y     (Y),
    .Z     (Z)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [2*N-1:0] act,
                       input logic [2*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Apply operands on a falling edge, then check after N+4 cycles.
  task automatic run_vec(input string tag, input logic [N-1:0] x,
                         input logic [N-1:0] y, input logic [2*N-1:0] exp);
    X = x;
    Y = y;
    tick(N + 4);
    check(tag, Z, exp);
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b1;
    X     = '0;
    Y     = '0;
    #5;
    check("reset_z", Z, 64'h0);
    @(negedge clock);
    reset = 1'b1;

    run_vec("2x4",        32'd2,          32'd4,          64'd8);
    run_vec("wide",       32'h0008_0002,  32'h0400_0004,  64'h0000_2000_0820_0008);
    run_vec("zero_x",     32'd0,          32'h0400_0004,  64'h0);
    run_vec("one_x",      32'd1,          32'h0400_0004,  64'h0000_0000_0400_0004);
    run_vec("zero_neg",   32'd0,          -32'sd5,        64'h0);
    run_vec("m2x4",       -32'sd2,        32'd4,          64'hFFFF_FFFF_FFFF_FFF8);
    run_vec("m2xm4",      -32'sd2,        -32'sd4,        64'd8);
    run_vec("m7xm4",      -32'sd7,        -32'sd4,        64'd28);
    run_vec("2xm3",       32'd2,          -32'sd3,        64'hFFFF_FFFF_FFFF_FFFA);
    run_vec("min_sq",     32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
    run_vec("min_x1",     32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000);
    run_vec("max_min",    32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000);

    // Unchanged operands must leave Z alone.
    tick(2 * N);
    check("hold", Z, 64'hC000_0000_8000_0000);

    // Idle latency: capture on the first edge, Z on edge N+1.
    X = 32'd3;
    Y = 32'd5;
    tick(N);
    check("lat_before", Z, 64'hC000_0000_8000_0000);
    tick(1);
    check("lat_exact", Z, 64'd15);

    // en low for 5 cycles mid-run stretches latency by exactly 5.
    X = 32'd6;
    Y = 32'd7;
    tick(10);
    en = 1'b0;
    tick(5);
    check("stall_frozen", Z, 64'd15);
    en = 1'b1;
    tick(N + 1 + 5 - 15 - 1);
    check("stall_before", Z, 64'd15);
    tick(1);
    check("stall_exact", Z, 64'd42);

    // Operand change at RUN cycle 10 aborts; new product within N+2.
    X = 32'd9;
    Y = 32'd11;
    tick(11);
    check("abort_mid", Z, 64'd42);
    X = -32'sd3;
    Y = 32'd100;
    tick(N + 1);
    check("abort_before", Z, 64'd42);
    tick(1);
    check("abort_exact", Z, 64'hFFFF_FFFF_FFFF_FED4);

    // Reset mid-run clears Z at once, then recomputes after release.
    X = 32'd12;
    Y = -32'sd12;
    tick(10);
    reset = 1'b0;
    #1;
    check("rst_mid_z", Z, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    tick(N + 4);
    check("rst_recover", Z, 64'hFFFF_FFFF_FFFF_FF70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
